// File: rtl/rate_limit_water_pkg.sv
// Shared constants and the single-precision add used by the control-chain math cores.
package rate_limit_water_pkg;

  localparam int unsigned SINGLE    = 32;
  localparam int unsigned FP_SIGN_W = 1;
  localparam int unsigned FP_EXP_W  = 8;
  localparam int unsigned FP_MAN_W  = 23;

  localparam logic [7:0]        FP_EXP_ALL1 = 8'hFF;
  localparam logic [SINGLE-1:0] FP_QNAN     = 32'h7FC00000;

  localparam logic OP_ADD   = 1'b1;
  localparam logic OP_SUB   = 1'b0;
  localparam logic ENA_MATH = 1'b1;

  // IEEE-754 single add, round-to-nearest-even, denormals supported.
  function automatic logic [SINGLE-1:0] fp_add(input logic [SINGLE-1:0] a,
                                               input logic [SINGLE-1:0] b);
    logic [31:0] big, sml;
    logic [7:0]  eb, es, d;
    logic [26:0] mb, ms, ms_sh;
    logic [27:0] s;
    logic [24:0] mant;
    logic        a_nan, b_nan, a_inf, b_inf, rnd;
    int          e;
    a_nan = (a[30:23] == FP_EXP_ALL1) && (a[22:0] != '0);
    b_nan = (b[30:23] == FP_EXP_ALL1) && (b[22:0] != '0);
    a_inf = (a[30:23] == FP_EXP_ALL1) && (a[22:0] == '0);
    b_inf = (b[30:23] == FP_EXP_ALL1) && (b[22:0] == '0);
    if (a_nan || b_nan) return FP_QNAN;
    if (a_inf) return (b_inf && (a[31] != b[31])) ? FP_QNAN : a;
    if (b_inf) return b;
    if (a[30:0] >= b[30:0]) begin
      big = a;
      sml = b;
    end else begin
      big = b;
      sml = a;
    end
    // Denormals share the minimum exponent with an implicit leading zero.
    eb = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
    es = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
    mb = {big[30:23] != 8'd0, big[22:0], 3'b000};
    ms = {sml[30:23] != 8'd0, sml[22:0], 3'b000};
    d  = eb - es;
    if (d >= 8'd27) begin
      ms_sh = {26'd0, |ms};
    end else begin
      ms_sh    = ms >> d;
      ms_sh[0] = ms_sh[0] | (|(ms & ((27'd1 << d) - 27'd1)));
    end
    if (big[31] == sml[31]) s = {1'b0, mb} + {1'b0, ms_sh};
    else                    s = {1'b0, mb} - {1'b0, ms_sh};
    // Exact cancellation gives +0; two zeros of the same sign keep it.
    if (s == '0) return {big[31] & sml[31], 31'd0};
    e = int'(eb);
    if (s[27]) begin
      s = {1'b0, s[27:2], s[1] | s[0]};
      e = e + 1;
    end else begin
      for (int i = 0; i < 26; i++) begin
        if (!s[26] && (e > 1)) begin
          s = s << 1;
          e = e - 1;
        end
      end
    end
    rnd  = s[2] & (s[1] | s[0] | s[3]);
    mant = {1'b0, s[26:3]} + {24'd0, rnd};
    if (mant[24]) begin
      mant = mant >> 1;
      e    = e + 1;
    end
    if (e >= 255) return {big[31], FP_EXP_ALL1, 23'd0};
    return {big[31], mant[23] ? 8'(e) : 8'd0, mant[22:0]};
  endfunction

endpackage

// File: rtl/adder_nodsp.sv
// Pipelined single-precision add/sub core; result is valid Latency enabled clocks after inputs.
module adder_nodsp
  import rate_limit_water_pkg::*;
#(
  parameter int unsigned Latency = 7
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic              clk_en,
  input  logic              add_sub,
  input  logic [SINGLE-1:0] dataa,
  input  logic [SINGLE-1:0] datab,
  output logic [SINGLE-1:0] result
);

  logic [SINGLE-1:0] pipe_q [Latency];
  logic [SINGLE-1:0] operand_b;

  // Subtraction is addition of the sign-flipped operand.
  always_comb operand_b = add_sub ? datab : {~datab[31], datab[30:0]};

  // Delay line carrying the sum through the configured latency.
  always_ff @(posedge clk) begin
    if (aclr) begin
      for (int i = 0; i < int'(Latency); i++) pipe_q[i] <= '0;
    end else if (clk_en) begin
      pipe_q[0] <= fp_add(dataa, operand_b);
      for (int i = 1; i < int'(Latency); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign result = pipe_q[Latency-1];

endmodule

// File: rtl/float_cmp_single.sv
// Combinational single-precision compare: sign-magnitude order, +0 == -0, NaN unordered.
module float_cmp_single
  import rate_limit_water_pkg::*;
(
  input  logic [SINGLE-1:0] a,
  input  logic [SINGLE-1:0] b,
  output logic              lt,
  output logic              gt,
  output logic              eq,
  output logic              a_nan
);

  logic               b_nan;
  logic signed [32:0] key_a, key_b;

  // Map magnitudes onto a signed number line so both zeros land on 0.
  always_comb begin
    a_nan = (a[30:23] == FP_EXP_ALL1) && (a[22:0] != '0);
    b_nan = (b[30:23] == FP_EXP_ALL1) && (b[22:0] != '0);
    key_a = a[31] ? -$signed({2'b00, a[30:0]}) : $signed({2'b00, a[30:0]});
    key_b = b[31] ? -$signed({2'b00, b[30:0]}) : $signed({2'b00, b[30:0]});
    lt    = !a_nan && !b_nan && (key_a < key_b);
    gt    = !a_nan && !b_nan && (key_a > key_b);
    eq    = !a_nan && !b_nan && (key_a == key_b);
  end

endmodule

// File: rtl/rate_limit_water.sv
// Slew-rate limiter: each start moves y toward x by at most RATE_STEP.
module rate_limit_water
  import rate_limit_water_pkg::*;
#(
  parameter logic [SINGLE-1:0] RATE_STEP   = 32'h3F000000,
  parameter logic [SINGLE-1:0] INIT_VALUE  = 32'h00000000,
  parameter int unsigned       ADD_LATENCY = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rst_user,
  input  logic              sta,
  input  logic [SINGLE-1:0] x,
  output logic [SINGLE-1:0] y,
  output logic              done_sig
);

  localparam int unsigned CntW = $clog2(ADD_LATENCY + 1);

  typedef enum logic [1:0] {StIdle, StAdd, StCmp, StOut} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [SINGLE-1:0] x_q, x_d, yprev_q, yprev_d, y_q, y_d;
  logic [SINGLE-1:0] lo, hi;
  logic              done_q, done_d;
  logic              lt_q, lt_d, inband_q, inband_d, nan_q, nan_d;
  logic              lo_lt, lo_gt, lo_eq, lo_nan, hi_lt, hi_gt, hi_eq, hi_nan;

  adder_nodsp #(.Latency(ADD_LATENCY)) u_add_hi (
    .clk    (clk),
    .aclr   (1'b0),
    .clk_en (ENA_MATH),
    .add_sub(OP_ADD),
    .dataa  (yprev_q),
    .datab  (RATE_STEP),
    .result (hi)
  );

  adder_nodsp #(.Latency(ADD_LATENCY)) u_add_lo (
    .clk    (clk),
    .aclr   (1'b0),
    .clk_en (ENA_MATH),
    .add_sub(OP_SUB),
    .dataa  (yprev_q),
    .datab  (RATE_STEP),
    .result (lo)
  );

  float_cmp_single u_cmp_lo (
    .a    (x_q),
    .b    (lo),
    .lt   (lo_lt),
    .gt   (lo_gt),
    .eq   (lo_eq),
    .a_nan(lo_nan)
  );

  float_cmp_single u_cmp_hi (
    .a    (x_q),
    .b    (hi),
    .lt   (hi_lt),
    .gt   (hi_gt),
    .eq   (hi_eq),
    .a_nan(hi_nan)
  );

  // Step sequencing; the counter alone decides when the adder results are valid.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    yprev_d  = yprev_q;
    y_d      = y_q;
    done_d   = 1'b0;
    lt_d     = lt_q;
    inband_d = inband_q;
    nan_d    = nan_q;
    case (state_q)
      StIdle: begin
        if (sta) begin
          x_d     = x;
          yprev_d = y_q;
          cnt_d   = '0;
          state_d = StAdd;
        end
      end
      StAdd: begin
        if (cnt_q == CntW'(ADD_LATENCY - 1)) state_d = StCmp;
        else                                 cnt_d   = cnt_q + 1'b1;
      end
      StCmp: begin
        lt_d     = lo_lt;
        inband_d = (lo_gt || lo_eq) && (hi_lt || hi_eq);
        nan_d    = lo_nan || hi_nan;
        state_d  = StOut;
      end
      StOut: begin
        done_d = 1'b1;
        // Not NaN, not below lo and not within band means above hi.
        if (nan_q)          y_d = y_q;
        else if (lt_q)      y_d = lo;
        else if (!inband_q) y_d = hi;
        else                y_d = x_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; either reset aborts a step in progress without a done pulse.
  always_ff @(posedge clk) begin
    if (rst || rst_user) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      y_q     <= INIT_VALUE;
      done_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      yprev_q  <= yprev_d;
      y_q      <= y_d;
      done_q   <= done_d;
      lt_q     <= lt_d;
      inband_q <= inband_d;
      nan_q    <= nan_d;
    end
  end

  assign y        = y_q;
  assign done_sig = done_q;

endmodule

// File: tb/tb_rate_limit_water.sv
// Bench for rate_limit_water: vector table, random steps against a real-valued model,
// and hand sequences for ignored starts and mid-step resets.
module tb_rate_limit_water;

  logic        clk = 1'b0;
  logic        rst, rst_user, sta, done_sig;
  logic [31:0] x, y;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] y_m;

  always #5 clk = ~clk;

  rate_limit_water dut (
    .clk     (clk),
    .rst     (rst),
    .rst_user(rst_user),
    .sta     (sta),
    .x       (x),
    .y       (y),
    .done_sig(done_sig)
  );

  typedef struct {
    logic [31:0] x;
    logic [31:0] exp_y;
  } vec_t;

  vec_t vecs[12];

  task automatic check_bits(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic real pow2(input int n);
    real r = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
    else        for (int i = 0; i < -n; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic bit is_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  function automatic real b2r(input logic [31:0] v);
    real mag;
    int  e, m;
    e = int'(v[30:23]);
    m = int'(v[22:0]);
    if (e == 255)    mag = 1.0e30;
    else if (e == 0) mag = real'(m) * pow2(-149);
    else             mag = (8388608.0 + real'(m)) * pow2(e - 150);
    return v[31] ? -mag : mag;
  endfunction

  // Only used for values exactly representable as normal singles (or zero).
  function automatic logic [31:0] r2b(input real v);
    real a;
    int  e, mant;
    logic s;
    if (v == 0.0) return 32'h0;
    s = (v < 0.0);
    a = s ? -v : v;
    e = 0;
    for (int i = 0; i < 300; i++) if (a >= 2.0) begin a = a / 2.0; e++; end
    for (int i = 0; i < 300; i++) if (a < 1.0) begin a = a * 2.0; e--; end
    mant = $rtoi((a - 1.0) * 8388608.0);
    return {s, 8'(e + 127), 23'(mant)};
  endfunction

  // Reference: clamp x into [y-0.5, y+0.5]; NaN leaves y alone; in-band keeps x's bits.
  function automatic logic [31:0] model_step(input logic [31:0] yp, input logic [31:0] xv);
    real xr, lo, hi;
    if (is_nan(xv)) return yp;
    xr = b2r(xv);
    lo = b2r(yp) - 0.5;
    hi = b2r(yp) + 0.5;
    if (xr < lo) return r2b(lo);
    if (xr > hi) return r2b(hi);
    return xv;
  endfunction

  task automatic run_step(input logic [31:0] xv, output logic [31:0] yv, output int lat,
                          output int ndone, output int moved);
    logic [31:0] y_before;
    @(negedge clk);
    y_before = y;
    sta = 1'b1;
    x   = xv;
    @(posedge clk);
    #1;
    sta = 1'b0;
    x   = $urandom;
    lat = -1; ndone = 0; moved = 0; yv = y;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk);
      #1;
      if (lat < 0 && !done_sig && y !== y_before) moved++;
      if (done_sig) begin
        ndone++;
        if (lat < 0) begin
          lat = c;
          yv  = y;
        end
      end
    end
  endtask

  task automatic step_and_check(input string nm, input logic [31:0] xv, input logic [31:0] exp);
    logic [31:0] yv;
    int lat, nd, mv;
    run_step(xv, yv, lat, nd, mv);
    check_bits({nm, " y"}, yv, exp);
    check_int({nm, " latency"}, lat, 9);
    check_int({nm, " done count"}, nd, 1);
    check_int({nm, " y early change"}, mv, 0);
    check_bits({nm, " y held"}, y, exp);
    y_m = exp;
  endtask

  task automatic abort_step(input string nm, input logic [31:0] xv, input int k,
                            input logic r, input logic ru);
    int nd;
    @(negedge clk);
    sta = 1'b1;
    x   = xv;
    @(posedge clk);
    #1;
    sta = 1'b0;
    nd  = 0;
    for (int c = 1; c <= 14; c++) begin
      if (c == k) begin
        rst      = r;
        rst_user = ru;
      end
      @(posedge clk);
      #1;
      if (c == k) begin
        rst      = 1'b0;
        rst_user = 1'b0;
        check_bits({nm, " y after reset"}, y, 32'h0);
      end
      if (done_sig) nd++;
    end
    check_int({nm, " done count"}, nd, 0);
    y_m = 32'h0;
    step_and_check({nm, " next step"}, 32'h3F800000, 32'h3F000000);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] x1, x2, yv, exp;
    int lat, nd;

    vecs[0]  = '{32'h3F800000, 32'h3F000000};
    vecs[1]  = '{32'h3F800000, 32'h3F800000};
    vecs[2]  = '{32'hBF800000, 32'h3F000000};
    vecs[3]  = '{32'h3F400000, 32'h3F400000};
    vecs[4]  = '{32'h00000000, 32'h3E800000};
    vecs[5]  = '{32'h3F000000, 32'h3F000000};
    vecs[6]  = '{32'h7FC00000, 32'h3F000000};
    vecs[7]  = '{32'hFF800000, 32'h00000000};
    vecs[8]  = '{32'h7F800000, 32'h3F000000};
    vecs[9]  = '{32'h00000001, 32'h00000001};
    vecs[10] = '{32'h80000000, 32'h80000000};
    vecs[11] = '{32'h00000000, 32'h00000000};

    rst = 1'b1; rst_user = 1'b0; sta = 1'b0; x = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_bits("reset y", y, 32'h0);
    check_int("reset done", int'(done_sig), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) step_and_check($sformatf("vec%0d", i), vecs[i].x, vecs[i].exp_y);

    // Random steps on a 1/64 grid so y +/- 0.5 stays exact in the real-valued model.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] xr;
      int k;
      k  = int'($urandom_range(512)) - 256;
      xr = ($urandom_range(15) == 0) ? 32'h7FC00000 : r2b(real'(k) / 64.0);
      step_and_check($sformatf("rand%0d", i), xr, model_step(y_m, xr));
    end

    // A second start three cycles in must be ignored entirely.
    x1  = r2b(b2r(y_m) + 3.0);
    x2  = r2b(b2r(y_m) - 3.0);
    exp = model_step(y_m, x1);
    @(negedge clk);
    sta = 1'b1;
    x   = x1;
    @(posedge clk);
    #1;
    sta = 1'b0;
    lat = -1; nd = 0; yv = y;
    for (int c = 1; c <= 14; c++) begin
      if (c == 3) begin
        sta = 1'b1;
        x   = x2;
      end
      @(posedge clk);
      #1;
      if (c == 3) sta = 1'b0;
      if (done_sig) begin
        nd++;
        if (lat < 0) begin
          lat = c;
          yv  = y;
        end
      end
    end
    check_bits("ignored sta y", yv, exp);
    check_int("ignored sta done count", nd, 1);
    check_int("ignored sta latency", lat, 9);
    check_bits("ignored sta y held", y, exp);
    y_m = exp;

    abort_step("rst_user mid-step", 32'h40800000, 5, 1'b0, 1'b1);
    abort_step("rst mid-step", 32'hC0800000, 5, 1'b1, 1'b0);
    abort_step("both resets", 32'h40800000, 4, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rate_limit_water.md
Name: rate_limit_water

Overview:
- Slew-rate limiter sitting directly downstream of the limited PI controller in the water/turbine control chain.
- Once per simulation time step it moves its held output toward the PI output `x` by at most `RATE_STEP`: y_new = clamp(x, y_prev − RATE_STEP, y_prev + RATE_STEP).
- All data is IEEE-754 single precision; the start/done handshake matches the other control-system stages.

Parameters:
- `RATE_STEP`, 32'h3F000000, max |Δy| per step (max_rate·delta_t), positive single; must not be NaN/Inf.
- `INIT_VALUE`, 32'h00000000, value of `y` after `rst` or `rst_user`.
- `ADD_LATENCY`, 7, pipeline latency in clocks of the shared `Adder_nodsp` core.

Ports:
- `clk`  in  1  system clock; the block uses one clock.
- `rst`  in  1  reset; synchronous, active-high.
- `rst_user`  in  1  user reset, synchronous, active-high; returns state to `INIT_VALUE`.
- `sta`  in  1  start pulse, one per time step; samples `x`.
- `x`  in  `SINGLE`  PI output to be limited (single float).
- `y`  out  `SINGLE`  rate-limited output, held between steps.
- `done_sig`  out  1  one-cycle pulse marking the cycle `y` takes its new value.

Behaviour:
- Reset (`rst` or `rst_user` high at a clock edge):
  - state → IDLE, `y` = `INIT_VALUE`, `done_sig` = 0, busy counter cleared.
  - `rst` has priority; both abort any step in progress with no `done_sig`.
- Adder instantiation: two `Adder_nodsp` instances compute y_prev + `RATE_STEP` (hi) and y_prev − `RATE_STEP` (lo).
  - `aclr` is tied 0 and `clk_en` is tied to `ena_math`.
  - Correctness depends only on the FSM counter; no adder reset is relied on.
- FSM states: IDLE, ADD, CMP, OUT.
  - IDLE: when `sta`=1, latch `x` into `x_r` and y_prev = `y`, clear the counter, go to ADD. Otherwise stay.
  - ADD: adder operands are held constant from `x_r`/y_prev. Count `ADD_LATENCY` cycles, then go to CMP.
  - CMP: register `x_r` < lo, `x_r` > hi, and `x_r` is NaN, then go to OUT.
  - OUT: update `y` and pulse `done_sig`=1 for this cycle only, then go to IDLE.
- Selection in OUT, in priority order:
  - `x_r` is NaN → `y` unchanged.
  - `x_r` < lo → `y` = lo.
  - `x_r` > hi → `y` = hi.
  - else → `y` = `x_r`, bit-exact.
- Latency: with `sta` sampled at edge s, `done_sig` is high and `y` is valid at cycle s + `ADD_LATENCY` + 2 (s+9 by default).
- Throughput: one step per `ADD_LATENCY` + 3 cycles.
- `sta` is accepted only in IDLE. `sta` in ADD/CMP/OUT is ignored: not queued, no effect.
- `x` is ignored except at the accepting edge.
- `y` changes only in OUT or on reset; it is stable at all other times.
- Comparison rules (`float_cmp_single`):
  - sign-magnitude ordering; +0 and −0 compare equal.
  - denormals ordered by raw magnitude.
  - exp=FF with mantissa≠0 is NaN.
  - ±Inf ordered normally, so x=+Inf → y = hi.
- Lo/hi are exactly the adder's IEEE-rounded results; no extra rounding is applied.

Decomposition:
- Shared package/include, existing global parameter file:
  - `SINGLE`=32, `add`/`sub` opcode constants, `ena_math`.
  - new constants `FP_EXP_ALL1`=8'hFF and FP field widths (1/8/23).
- FSM state encoding is local parameters.
- One natural sub-module: `float_cmp_single`.
  - combinational: inputs a, b; outputs lt, gt, eq, a_nan.
  - reusable by the `limit_control_system_water` family.

Test Plan:
- Defaults, after `rst`; `sta` with x=32'h3F800000 (1.0) → done at sta+9, y=32'h3F000000 (0.5). Repeat → y=32'h3F800000 (1.0).
- From y=1.0, x=32'hBF800000 (−1.0) → y=32'h3F000000 (0.5). Then x=32'h3F400000 (0.75) → y=32'h3F400000 exactly (within band).
- x=32'h7FC00000 (NaN) → `done_sig` pulses, y unchanged. x=32'hFF800000 (−Inf) from y=0.5 → y=32'h00000000.
- Second `sta` at sta+3 → ignored: exactly one `done_sig`, result equals the first-sample computation, and the new x has no effect.
- `rst_user` asserted at sta+5 → y=`INIT_VALUE` next cycle, no `done_sig` for that step, and the next `sta` runs normally from 0.
- From y=32'h80000000 (−0.0), x=32'h00000000 (+0.0) → in-band, y=32'h00000000. With `rst` mid-step → same as the `rst_user` case, and `rst` wins if both are asserted.
